cv32e40p_x_result: RTL
======================

CV32E40P_X_RESULT -- requirements
Module: cv32e40p_x_result

Interface
REQ-001 SHALL have parameter DEPTH, default 2: result buffer entries; a power of two, at least 2.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port x_result_valid_i, input, 1: coprocessor result valid.
REQ-005 SHALL have port x_result_ready_o, output, 1: block accepts the result this cycle.
REQ-006 SHALL have port x_result_rd_i, input, 5: destination register address.
REQ-007 SHALL have port x_result_data_i, input, 32: result data.
REQ-008 SHALL have port x_result_we_i, input, 1: result carries a register write.
REQ-009 SHALL have port wb_free_i, input, 1: the core does not use register-file write port B this cycle.
REQ-010 SHALL have port x_rf_we_o, output, 1: write enable on register-file write port B.
REQ-011 SHALL have port x_rf_waddr_o, output, 5: write address on port B.
REQ-012 SHALL have port x_rf_wdata_o, output, 32: write data on port B.
REQ-013 SHALL have port x_rvalid_o, output, 1: scoreboard-clear pulse to the dispatcher.
REQ-014 SHALL have port x_rwaddr_o, output, 5: register whose scoreboard bit clears.
REQ-015 SHALL have port x_result_pending_o, output, 1: buffer is not empty.

Function
REQ-016 SHALL drive x_result_ready_o = ~full, from registered state only, with no combinational path from any input.
REQ-017 SHALL define a handshake as x_result_valid_i & x_result_ready_o; each handshake with x_result_we_i=1 SHALL push {rd, data} at the buffer tail.
REQ-018 SHALL accept a handshake with x_result_we_i=0 and discard it: no push, no write, no x_rvalid_o.
REQ-019 SHALL pop the head entry in any cycle where the buffer is not empty and wb_free_i=1.
REQ-020 In a pop cycle, SHALL drive x_rvalid_o=1 and x_rwaddr_o=head.rd combinationally.
REQ-021 In a pop cycle, SHALL drive x_rf_we_o=1, x_rf_waddr_o=head.rd and x_rf_wdata_o=head.data, except that x_rf_we_o=0 when head.rd=0.
REQ-022 Outside pop cycles, SHALL drive x_rf_we_o=0, x_rvalid_o=0, x_rf_waddr_o=0, x_rwaddr_o=0 and x_rf_wdata_o=0.
REQ-023 SHALL have a minimum latency of 1 cycle: a result pushed in cycle N is written no earlier than cycle N+1; there is no bypass.
REQ-024 SHALL retire results strictly in acceptance order (FIFO).
REQ-025 On simultaneous push and pop, SHALL keep the count unchanged and advance both pointers.
REQ-026 SHALL use pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count of $clog2(DEPTH)+1 bits; full when count=DEPTH, empty when count=0.
REQ-027 SHALL never overflow the buffer: a push while full is impossible because ready=0.
REQ-028 SHALL never underflow the buffer: no pop while empty, regardless of wb_free_i.
REQ-029 SHALL hold the head entry and all outputs stable while wb_free_i=0; there is no timeout.
REQ-030 SHALL have no flush input: accepted results always commit.

Reset
REQ-031 While rst_i=1, SHALL force count=0 and both pointers=0.
REQ-032 While rst_i=1, SHALL drive x_result_ready_o=1, x_result_pending_o=0, and all write/rvalid outputs to 0.
REQ-033 Assertion of rst_i mid-operation SHALL discard all buffered entries immediately, asynchronously, with no writes issued.
REQ-034 Buffer data storage SHALL not require reset.

Structure
REQ-035 SHALL place typedef x_result_t {rd[4:0], data[31:0]} in shared package cv32e40p_x_pkg.
REQ-036 SHALL place constant X_RESULT_DEPTH=2 in cv32e40p_x_pkg.
REQ-037 SHALL implement storage in one sub-module, cv32e40p_x_result_fifo (parameterised DEPTH, push/pop/full/empty).
REQ-038 SHALL keep the handshake, the x0 suppression and the output muxing in the top module.

Verification
REQ-039 Single result: push rd=5, data=0xDEADBEEF with wb_free_i=1 -> next cycle x_rf_we_o=1, x_rf_waddr_o=5, x_rf_wdata_o=0xDEADBEEF, x_rvalid_o=1, x_rwaddr_o=5; the cycle after, all outputs 0.
REQ-040 Backpressure: hold wb_free_i=0 and push rd=1 then rd=2 -> x_result_ready_o=0 after the second push. Raise wb_free_i -> writes rd=1, then rd=2, on consecutive cycles, and ready returns to 1 one cycle after the first pop.
REQ-041 x0 and no-write: push rd=0, we=1 -> x_rvalid_o=1, x_rwaddr_o=0, x_rf_we_o=0. Push we=0 -> no push, no outputs.
REQ-042 Wrap and simultaneous events: 10 back-to-back pushes rd=1..10 with wb_free_i=1 -> 10 writes in order on consecutive cycles, count never exceeds 1, and pointers wrap cleanly.
REQ-043 Reset mid-operation: with 2 buffered entries, pulse rst_i asynchronously -> x_result_pending_o=0 and x_result_ready_o=1 immediately, and no write follows after reset is released.

Source files
------------

// File: rtl/cv32e40p_x_pkg.sv
// Shared types and constants for the coprocessor result path.
// The result buffer entry carries the destination register and its data.
package cv32e40p_x_pkg;

    localparam int X_RESULT_DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } x_result_t;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Result buffer storage: DEPTH-entry FIFO with wrapping pointers and an occupancy count.
// Push while full and pop while empty are ignored, so the buffer can neither overflow nor underflow.
module cv32e40p_x_result_fifo
    import cv32e40p_x_pkg::*;
#(
    parameter int DEPTH = X_RESULT_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  x_result_t wdata,
    output x_result_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    x_result_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Entry storage; contents are only meaningful below the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth makes pointer wrap implicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_x_result.sv
// Coprocessor result interface: buffers accepted results and retires them in order on
// register-file write port B whenever the core leaves that port free.
module cv32e40p_x_result
    import cv32e40p_x_pkg::*;
#(
    parameter int DEPTH = X_RESULT_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_result_valid_i,
    output logic        x_result_ready_o,
    input  logic [4:0]  x_result_rd_i,
    input  logic [31:0] x_result_data_i,
    input  logic        x_result_we_i,
    input  logic        wb_free_i,
    output logic        x_rf_we_o,
    output logic [4:0]  x_rf_waddr_o,
    output logic [31:0] x_rf_wdata_o,
    output logic        x_rvalid_o,
    output logic [4:0]  x_rwaddr_o,
    output logic        x_result_pending_o
);

    x_result_t push_entry_s;
    x_result_t head_s;
    logic      full_s;
    logic      empty_s;
    logic      push_s;
    logic      pop_s;

    // Ready depends only on buffer state; results without a write are accepted and dropped.
    assign x_result_ready_o   = ~full_s;
    assign x_result_pending_o = ~empty_s;
    assign push_s             = x_result_valid_i & x_result_ready_o & x_result_we_i;
    assign pop_s              = ~empty_s & wb_free_i;
    assign push_entry_s.rd    = x_result_rd_i;
    assign push_entry_s.data  = x_result_data_i;

    cv32e40p_x_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_entry_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Port-B write and scoreboard clear; x0 still clears its scoreboard bit but never writes.
    always_comb begin
        x_rf_we_o    = 1'b0;
        x_rf_waddr_o = 5'd0;
        x_rf_wdata_o = 32'd0;
        x_rvalid_o   = 1'b0;
        x_rwaddr_o   = 5'd0;
        if (pop_s) begin
            x_rf_we_o    = (head_s.rd != 5'd0);
            x_rf_waddr_o = head_s.rd;
            x_rf_wdata_o = head_s.data;
            x_rvalid_o   = 1'b1;
            x_rwaddr_o   = head_s.rd;
        end else begin
            x_rf_we_o    = 1'b0;
            x_rvalid_o   = 1'b0;
        end
    end

endmodule
